// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman accelerator.
//   - default character / score widths
//   - nucleotide encoding shared with the PE array
//   - pass-scheduler state type and a small state classifier
package sw_pkg;

   localparam int SW_CHAR_W  = 2;
   localparam int SW_SCORE_W = 16;

   localparam logic [1:0] NT_A = 2'd0;
   localparam logic [1:0] NT_C = 2'd1;
   localparam logic [1:0] NT_G = 2'd2;
   localparam logic [1:0] NT_T = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_STREAM,
      S_DRAIN,
      S_NEXT,
      S_FIN
   } sched_state_e;

   // A job is "busy" everywhere except IDLE and the FIN (done) cycle.
   function automatic logic is_busy_state(input sched_state_e s);
      return s inside {S_LOAD, S_STREAM, S_DRAIN, S_NEXT};
   endfunction

endpackage

// File: rtl/sw_pass_scheduler_if.sv
// Bus bundle of the pass scheduler: host command/result, query and target
// RAM read ports, and the PE-array load/stream/score port.
//   master : scheduler side (drives status, RAM reads, PE control)
//   slave  : environment side (host, RAMs, PE array)
interface sw_pass_scheduler_if
   import sw_pkg::*;
#(
   parameter int PE_NUM   = 64,
   parameter int Q_ADDR_W = 10,
   parameter int T_ADDR_W = 16,
   parameter int CHAR_W   = SW_CHAR_W,
   parameter int SCORE_W  = SW_SCORE_W
);
   localparam int IDX_W = $clog2(PE_NUM);

   logic                start;
   logic [Q_ADDR_W:0]   q_len;
   logic [T_ADDR_W:0]   t_len;
   logic                busy;
   logic                done;
   logic [SCORE_W-1:0]  max_score;

   logic                q_rd_en;
   logic [Q_ADDR_W-1:0] q_rd_addr;
   logic [CHAR_W-1:0]   q_rd_data;
   logic                t_rd_en;
   logic [T_ADDR_W-1:0] t_rd_addr;
   logic [CHAR_W-1:0]   t_rd_data;

   logic                pe_load_en;
   logic [IDX_W-1:0]    pe_load_idx;
   logic [CHAR_W-1:0]   pe_load_char;
   logic                pe_load_valid;
   logic                pe_t_valid;
   logic [CHAR_W-1:0]   pe_t_char;
   logic                pe_first_pass;
   logic                pe_last_pass;
   logic                pe_score_valid;
   logic [SCORE_W-1:0]  pe_score;

   modport master (
      input  start, q_len, t_len, q_rd_data, t_rd_data, pe_score_valid, pe_score,
      output busy, done, max_score, q_rd_en, q_rd_addr, t_rd_en, t_rd_addr,
             pe_load_en, pe_load_idx, pe_load_char, pe_load_valid,
             pe_t_valid, pe_t_char, pe_first_pass, pe_last_pass
   );

   modport slave (
      output start, q_len, t_len, q_rd_data, t_rd_data, pe_score_valid, pe_score,
      input  busy, done, max_score, q_rd_en, q_rd_addr, t_rd_en, t_rd_addr,
             pe_load_en, pe_load_idx, pe_load_char, pe_load_valid,
             pe_t_valid, pe_t_char, pe_first_pass, pe_last_pass
   );

endinterface

// File: rtl/sw_max_tracker.sv
// Registered running maximum (unsigned).
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the maximum (wins over upd_en)
//   upd_en   : upd_val is a candidate this cycle
//   upd_val  : candidate value
//   max_val  : running maximum
module sw_max_tracker
   import sw_pkg::*;
#(
   parameter int SCORE_W = SW_SCORE_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               upd_en,
   input  logic [SCORE_W-1:0] upd_val,
   output logic [SCORE_W-1:0] max_val
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         max_val <= '0;
      end else if (upd_en && (upd_val > max_val)) begin
         max_val <= upd_val;
      end
   end

endmodule

// File: rtl/sw_pass_scheduler.sv
// Pass scheduler for the Smith-Waterman systolic array. A query longer than
// PE_NUM is split into passes; each pass loads PE_NUM query characters into
// the PEs (padding past q_len), streams the whole target, then drains.
//   clk, rst : clock, synchronous active-high reset
//   bus      : host start/q_len/t_len -> busy/done/max_score,
//              query/target RAM reads (1-cycle latency),
//              PE load/stream/pass-boundary control and score input
module sw_pass_scheduler
   import sw_pkg::*;
#(
   parameter int PE_NUM   = 64,
   parameter int Q_ADDR_W = 10,
   parameter int T_ADDR_W = 16,
   parameter int CHAR_W   = SW_CHAR_W,
   parameter int SCORE_W  = SW_SCORE_W
) (
   input  logic                clk,
   input  logic                rst,
   sw_pass_scheduler_if.master bus
);

   localparam int IDX_W = $clog2(PE_NUM);
   localparam int PB_W  = Q_ADDR_W + 1;
   // Phase counter must reach t_len (up to 2^T_ADDR_W) and PE_NUM+1.
   localparam int CNT_W = (T_ADDR_W + 2 > IDX_W + 3) ? T_ADDR_W + 2 : IDX_W + 3;
   // One extra bit so pass_base+offset never wraps before comparing to q_len.
   localparam int SUM_W = ((PB_W > CNT_W) ? PB_W : CNT_W) + 1;

   sched_state_e        state, state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [PB_W-1:0]     pass_base;
   logic [PB_W-1:0]     q_len_r;
   logic [T_ADDR_W:0]   t_len_r;
   logic [SUM_W-1:0]    ld_pos, ld_pos_m1, pb_next, q_len_x;
   logic                accept, busy_i, score_en;
   logic                ld_valid;
   logic [SCORE_W-1:0]  max_q;

   assign accept    = (state == S_IDLE) && bus.start;
   assign busy_i    = is_busy_state(state);
   assign ld_pos    = SUM_W'(pass_base) + SUM_W'(cnt);
   assign ld_pos_m1 = ld_pos - SUM_W'(1);
   assign pb_next   = SUM_W'(pass_base) + SUM_W'(PE_NUM);
   assign q_len_x   = SUM_W'(q_len_r);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (bus.start)
                      state_nxt = (bus.q_len == '0 || bus.t_len == '0) ? S_FIN : S_LOAD;
         S_LOAD:   if (cnt == CNT_W'(PE_NUM))     state_nxt = S_STREAM;
         S_STREAM: if (cnt == CNT_W'(t_len_r))    state_nxt = S_DRAIN;
         S_DRAIN:  if (cnt == CNT_W'(PE_NUM + 1)) state_nxt = S_NEXT;
         S_NEXT:   state_nxt = (pb_next >= q_len_x) ? S_FIN : S_LOAD;
         S_FIN:    state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Phase counter restarts at 0 on every state entry; job lengths latch on accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         pass_base <= '0;
         q_len_r   <= '0;
         t_len_r   <= '0;
      end else begin
         cnt <= (state_nxt != state || state == S_IDLE) ? '0 : cnt + CNT_W'(1);
         if (accept) begin
            q_len_r   <= bus.q_len;
            t_len_r   <= bus.t_len;
            pass_base <= '0;
         end else if (state == S_NEXT) begin
            pass_base <= PB_W'(pb_next);
         end
      end
   end

   // Output logic. Load cycle i issues the read for PE i and writes PE i-1
   // with the data returned from the previous cycle's read.
   always_comb begin
      bus.busy          = busy_i;
      bus.done          = (state == S_FIN);
      bus.q_rd_en       = 1'b0;
      bus.q_rd_addr     = '0;
      bus.t_rd_en       = 1'b0;
      bus.t_rd_addr     = '0;
      bus.pe_load_en    = 1'b0;
      bus.pe_load_idx   = '0;
      bus.pe_load_char  = '0;
      bus.pe_load_valid = 1'b0;
      bus.pe_t_valid    = 1'b0;
      bus.pe_t_char     = '0;
      bus.pe_first_pass = busy_i && (pass_base == '0);
      bus.pe_last_pass  = busy_i && (pb_next >= q_len_x);
      ld_valid          = ld_pos_m1 < q_len_x;
      case (state)
         S_LOAD: begin
            if (cnt < CNT_W'(PE_NUM)) begin
               bus.q_rd_addr = ld_pos[Q_ADDR_W-1:0];
               bus.q_rd_en   = ld_pos < q_len_x;
            end
            if (cnt != '0) begin
               bus.pe_load_en    = 1'b1;
               bus.pe_load_idx   = IDX_W'(cnt - CNT_W'(1));
               bus.pe_load_valid = ld_valid;
               bus.pe_load_char  = ld_valid ? bus.q_rd_data : '0;
            end
         end
         S_STREAM: begin
            if (cnt < CNT_W'(t_len_r)) begin
               bus.t_rd_en   = 1'b1;
               bus.t_rd_addr = cnt[T_ADDR_W-1:0];
            end
            if (cnt != '0) begin
               bus.pe_t_valid = 1'b1;
               bus.pe_t_char  = bus.t_rd_data;
            end
         end
         default: ;
      endcase
   end

   // Scores count in every busy cycle and in the FIN cycle.
   assign score_en = bus.pe_score_valid && (busy_i || state == S_FIN);

   sw_max_tracker #(.SCORE_W(SCORE_W)) u_max (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept),
      .upd_en  (score_en),
      .upd_val (bus.pe_score),
      .max_val (max_q)
   );

   assign bus.max_score = max_q;

endmodule

// File: tb/tb_sw_pass_scheduler.sv
module tb_sw_pass_scheduler;
   import sw_pkg::*;

   localparam int PE = 4;
   localparam int QW = 10;
   localparam int TW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sw_pass_scheduler_if #(.PE_NUM(PE), .Q_ADDR_W(QW), .T_ADDR_W(TW),
                          .CHAR_W(2), .SCORE_W(16)) bus();

   sw_pass_scheduler #(.PE_NUM(PE), .Q_ADDR_W(QW), .T_ADDR_W(TW),
                       .CHAR_W(2), .SCORE_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // RAM models with one-cycle read latency
   logic [1:0] q_mem [1024];
   logic [1:0] t_mem [256];
   always @(posedge clk) begin
      if (bus.q_rd_en) bus.q_rd_data <= q_mem[bus.q_rd_addr];
      if (bus.t_rd_en) bus.t_rd_data <= t_mem[bus.t_rd_addr[7:0]];
   end

   typedef struct packed {
      logic          busy;
      logic          done;
      logic          q_rd_en;
      logic [QW-1:0] q_rd_addr;
      logic          pe_load_en;
      logic [1:0]    pe_load_idx;
      logic [1:0]    pe_load_char;
      logic          pe_load_valid;
      logic          t_rd_en;
      logic [TW-1:0] t_rd_addr;
      logic          pe_t_valid;
      logic [1:0]    pe_t_char;
      logic          first;
      logic          last;
   } obs_t;

   typedef struct {
      int ql;
      int tl;
      int passes;
      int done_cyc;
      int qrd;
      int trd;
   } vec_t;

   vec_t tbl [7];
   obs_t exp_q [$];
   int   n_err = 0;
   int   n_chk = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   function automatic obs_t get_obs();
      obs_t o;
      o.busy          = bus.busy;
      o.done          = bus.done;
      o.q_rd_en       = bus.q_rd_en;
      o.q_rd_addr     = bus.q_rd_addr;
      o.pe_load_en    = bus.pe_load_en;
      o.pe_load_idx   = bus.pe_load_idx;
      o.pe_load_char  = bus.pe_load_char;
      o.pe_load_valid = bus.pe_load_valid;
      o.t_rd_en       = bus.t_rd_en;
      o.t_rd_addr     = bus.t_rd_addr;
      o.pe_t_valid    = bus.pe_t_valid;
      o.pe_t_char     = bus.pe_t_char;
      o.first         = bus.pe_first_pass;
      o.last          = bus.pe_last_pass;
      return o;
   endfunction

   // Reference schedule: the per-cycle output trace of one job, starting the
   // cycle after start is accepted, built pass by pass from the job's rules.
   task automatic build_trace(input int ql, input int tl);
      obs_t o;
      exp_q.delete();
      if (ql != 0 && tl != 0) begin
         for (int base = 0; base < ql; base += PE) begin
            for (int i = 0; i <= PE; i++) begin
               o = '0;
               o.busy = 1'b1; o.first = (base == 0); o.last = (base + PE >= ql);
               if (i < PE) begin
                  o.q_rd_addr = QW'(base + i);
                  o.q_rd_en   = (base + i < ql);
               end
               if (i >= 1) begin
                  o.pe_load_en    = 1'b1;
                  o.pe_load_idx   = 2'(i - 1);
                  o.pe_load_valid = (base + i - 1 < ql);
                  o.pe_load_char  = o.pe_load_valid ? q_mem[QW'(base + i - 1)] : 2'b00;
               end
               exp_q.push_back(o);
            end
            for (int j = 0; j <= tl; j++) begin
               o = '0;
               o.busy = 1'b1; o.first = (base == 0); o.last = (base + PE >= ql);
               if (j < tl) begin
                  o.t_rd_en   = 1'b1;
                  o.t_rd_addr = TW'(j);
               end
               if (j >= 1) begin
                  o.pe_t_valid = 1'b1;
                  o.pe_t_char  = t_mem[8'(j - 1)];
               end
               exp_q.push_back(o);
            end
            for (int k = 0; k < PE + 3; k++) begin   // drain cycles + the NEXT cycle
               o = '0;
               o.busy = 1'b1; o.first = (base == 0); o.last = (base + PE >= ql);
               exp_q.push_back(o);
            end
         end
      end
      o = '0;
      o.done = 1'b1;
      exp_q.push_back(o);
   endtask

   // mode 0: random scores; mode 1: fixed 3,9,9,2 with a gap
   task automatic run_job(input int ql, input int tl, input int mode, input bit spam,
                          output int done_cyc, output int n_pass, output int n_qrd,
                          output int n_trd, output int fin_max);
      obs_t o, e;
      int   mmax, sc, cyc;
      bit   v, got_done;
      build_trace(ql, tl);
      mmax = 0; done_cyc = -1; n_pass = 0; n_qrd = 0; n_trd = 0; got_done = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.q_len = 11'(ql); bus.t_len = 17'(tl);
      bus.pe_score_valid = 1'b1; bus.pe_score = 16'hFFFF;
      for (cyc = 2; cyc < 3000 && !got_done; cyc++) begin
         @(negedge clk);
         o = get_obs();
         e = (cyc - 2 < exp_q.size()) ? exp_q[cyc - 2] : '0;
         check($sformatf("trace j%0dx%0d c%0d", ql, tl, cyc), 64'(o), 64'(e));
         if (cyc == 2) check("max cleared on start", 64'(bus.max_score), 64'(0));
         if (o.pe_load_en && o.pe_load_idx == 2'd0) n_pass++;
         if (o.q_rd_en) n_qrd++;
         if (o.t_rd_en) n_trd++;
         bus.start = spam && (cyc % 2 == 1);
         bus.q_len = 11'($urandom);
         bus.t_len = 17'($urandom);
         if (mode == 1) begin
            case (cyc - 2)
               0: begin v = 1; sc = 3;  end
               1: begin v = 0; sc = 50; end
               2: begin v = 1; sc = 9;  end
               3: begin v = 1; sc = 9;  end
               4: begin v = 1; sc = 2;  end
               default: begin v = 0; sc = int'($urandom_range(0, 999)); end
            endcase
         end else begin
            v  = 1'($urandom_range(0, 1));
            sc = int'($urandom_range(0, 999));
         end
         bus.pe_score_valid = v;
         bus.pe_score = 16'(sc);
         if ((e.busy || e.done) && v && sc > mmax) mmax = sc;
         if (o.done) begin
            got_done = 1;
            done_cyc = cyc;
         end
      end
      if (!got_done) check("done timeout", 64'(0), 64'(1));
      // idle after done: outputs quiet, result held, idle scores ignored
      @(negedge clk);
      bus.start = 1'b0;
      check("idle after done", 64'(get_obs()), 64'(0));
      check("max after done", 64'(bus.max_score), 64'(mmax));
      bus.pe_score_valid = 1'b1; bus.pe_score = 16'hFFFF;
      repeat (2) @(negedge clk);
      check("max held in idle", 64'(bus.max_score), 64'(mmax));
      fin_max = int'(bus.max_score);
      bus.pe_score_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int dc, np, nq, nt, fm, ql, tl, edc;
      tbl[0] = '{ql: 4,  tl: 3, passes: 1, done_cyc: 18, qrd: 4,  trd: 3};
      tbl[1] = '{ql: 10, tl: 5, passes: 3, done_cyc: 56, qrd: 10, trd: 15};
      tbl[2] = '{ql: 0,  tl: 7, passes: 0, done_cyc: 2,  qrd: 0,  trd: 0};
      tbl[3] = '{ql: 5,  tl: 0, passes: 0, done_cyc: 2,  qrd: 0,  trd: 0};
      tbl[4] = '{ql: 8,  tl: 2, passes: 2, done_cyc: 32, qrd: 8,  trd: 4};
      tbl[5] = '{ql: 1,  tl: 1, passes: 1, done_cyc: 16, qrd: 1,  trd: 1};
      tbl[6] = '{ql: 3,  tl: 4, passes: 1, done_cyc: 19, qrd: 3,  trd: 4};

      for (int i = 0; i < 1024; i++) begin
         case ($urandom_range(0, 3))
            0: q_mem[i] = NT_A;
            1: q_mem[i] = NT_C;
            2: q_mem[i] = NT_G;
            default: q_mem[i] = NT_T;
         endcase
      end
      for (int i = 0; i < 256; i++) t_mem[i] = 2'($urandom);

      bus.start = 1'b0; bus.q_len = '0; bus.t_len = '0;
      bus.pe_score_valid = 1'b0; bus.pe_score = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset outputs", 64'(get_obs()), 64'(0));
      check("reset max", 64'(bus.max_score), 64'(0));
      rst = 1'b0;

      // table-driven jobs
      for (int i = 0; i < 7; i++) begin
         run_job(tbl[i].ql, tbl[i].tl, 0, 1'b0, dc, np, nq, nt, fm);
         check($sformatf("tbl%0d done cycle", i), 64'(dc), 64'(tbl[i].done_cyc));
         check($sformatf("tbl%0d passes", i), 64'(np), 64'(tbl[i].passes));
         check($sformatf("tbl%0d q reads", i), 64'(nq), 64'(tbl[i].qrd));
         check($sformatf("tbl%0d t reads", i), 64'(nt), 64'(tbl[i].trd));
      end

      // fixed score pattern, idle score ignored
      run_job(4, 3, 1, 1'b0, dc, np, nq, nt, fm);
      check("pattern max", 64'(fm), 64'(9));

      // start spammed while busy
      run_job(10, 5, 0, 1'b1, dc, np, nq, nt, fm);
      check("spam done cycle", 64'(dc), 64'(56));

      // reset in the middle of STREAM
      @(negedge clk);
      bus.start = 1'b1; bus.q_len = 11'(4); bus.t_len = 17'(6);
      bus.pe_score_valid = 1'b1; bus.pe_score = 16'd5;
      for (int c = 2; c <= 9; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      check("busy before abort", 64'(bus.pe_t_valid), 64'(1));
      check("max before abort", 64'(bus.max_score), 64'(5));
      rst = 1'b1;
      @(negedge clk);
      check("abort outputs", 64'(get_obs()), 64'(0));
      check("abort max", 64'(bus.max_score), 64'(0));
      rst = 1'b0;
      bus.pe_score_valid = 1'b0;
      @(negedge clk);
      check("idle after abort", 64'(get_obs()), 64'(0));
      run_job(4, 3, 0, 1'b0, dc, np, nq, nt, fm);
      check("post-abort done cycle", 64'(dc), 64'(18));

      // randomized jobs against the reference schedule
      for (int r = 0; r < 20; r++) begin
         ql = int'($urandom_range(0, 20));
         tl = int'($urandom_range(0, 12));
         run_job(ql, tl, 0, r[0], dc, np, nq, nt, fm);
         edc = (ql == 0 || tl == 0) ? 2 : 2 + ((ql + PE - 1) / PE) * (2 * PE + tl + 5);
         check($sformatf("rnd%0d done cycle", r), 64'(dc), 64'(edc));
         check($sformatf("rnd%0d q reads", r), 64'(nq), 64'((tl == 0) ? 0 : ql));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
